// File: rtl/g_arb_pkg.sv
// Shared definitions for the schematic-library arbiters: state encoding,
// idle output constants and a small modulo-3 helper for round-robin search.
package g_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam logic [1:0] OWN_NONE  = 2'b11;
  localparam logic [2:0] GNTN_IDLE = 3'b111;

  // (v + k) mod 3 for v in 0..2 and k in 0..3.
  function automatic logic [1:0] mod3_add(input logic [1:0] v, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, v} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/g_rr_pick3.sv
// Combinational 3-way round-robin picker: first active request searching
// from last+1 upward (mod 3); last itself has the lowest priority.
module g_rr_pick3
  import g_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand [3];
  logic [3:0] req_pad;

  assign req_pad = {1'b0, req_i};

  // cand[0] is the highest-priority candidate, cand[2] the lowest.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cand
      assign cand[gi] = mod3_add(last_i, 2'(gi + 1));
    end
  endgenerate

  always_comb begin
    valid_o = |req_i;
    idx_o   = cand[0];
    if (!req_pad[cand[0]]) begin
      idx_o = req_pad[cand[1]] ? cand[1] : cand[2];
    end
  end

endmodule

// File: rtl/g_3arb3.sv
// Three-requester round-robin arbiter with active-low requests, registered
// one-hot active-low grant, owner release strobe and optional grant timeout.
module g_3arb3
  import g_arb_pkg::*;
#(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15   // 0 disables the timeout; must be < 2**TMO_W
) (
  input  logic       CK,
  input  logic       CD,
  input  logic [2:0] REQN,
  input  logic       DONEN,
  output logic [2:0] GNTN,
  output logic       BUSY,
  output logic [1:0] OWN,
  output logic       TMO
);

  localparam bit              TMO_EN   = (TMO_MAX != 0);
  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO_MAX == 0 ? 0 : TMO_MAX - 1);

  arb_state_e       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [2:0]       gntn_q, gntn_d;
  logic             busy_q, busy_d;
  logic [1:0]       own_q, own_d;
  logic             tmo_q, tmo_d;

  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [3:0]       reqn_pad;
  logic             owner_gone;

  g_rr_pick3 u_pick (
    .req_i   (~REQN),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign reqn_pad   = {1'b1, REQN};
  assign owner_gone = reqn_pad[own_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gntn_d  = gntn_q;
    busy_d  = busy_q;
    own_d   = own_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          gntn_d  = ~(3'b001 << pick_idx);
          own_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        // Owner release wins over a coincident timeout, so TMO stays low then.
        if (!DONEN || owner_gone || (TMO_EN && cnt_q == CNT_LAST)) begin
          state_d = ST_IDLE;
          gntn_d  = GNTN_IDLE;
          busy_d  = 1'b0;
          own_d   = OWN_NONE;
          last_d  = own_q;
          tmo_d   = DONEN && !owner_gone;
        end else if (TMO_EN && cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;
      gntn_q  <= GNTN_IDLE;
      busy_q  <= 1'b0;
      own_q   <= OWN_NONE;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gntn_q  <= gntn_d;
      busy_q  <= busy_d;
      own_q   <= own_d;
      tmo_q   <= tmo_d;
    end
  end

  assign GNTN = gntn_q;
  assign BUSY = busy_q;
  assign OWN  = own_q;
  assign TMO  = tmo_q;

endmodule
